fq_measure_multi: RTL and testbench

//  Multi-channel reciprocal-free frequency counter. Counts rising edges of NCH asynchronous inputs

---
 rtl/fq_measure_pkg.sv | 32 +++
 rtl/fq_measure_multi_channel.sv | 63 ++++++
 rtl/fq_measure_multi.sv | 79 +++++++
 tb/tb_fq_measure_multi.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fq_measure_pkg.sv
// Shared types and gate-timing helpers for the multi-channel frequency counter.
package fq_measure_pkg;

    typedef enum logic [1:0] {
        GATE_1S    = 2'd0,
        GATE_100MS = 2'd1,
        GATE_10MS  = 2'd2,
        GATE_1MS   = 2'd3
    } gate_sel_t;

    // Largest scale is 1000, so the result product needs 10 extra bits.
    localparam int unsigned SCALE_W = 10;

    function automatic int unsigned gate_cycles(input int unsigned ref_freq, input gate_sel_t sel);
        case (sel)
            GATE_1S:    return ref_freq;
            GATE_100MS: return ref_freq / 10;
            GATE_10MS:  return ref_freq / 100;
            default:    return ref_freq / 1000;
        endcase
    endfunction

    function automatic logic [SCALE_W-1:0] gate_scale(input gate_sel_t sel);
        case (sel)
            GATE_1S:    return 10'd1;
            GATE_100MS: return 10'd10;
            GATE_10MS:  return 10'd100;
            default:    return 10'd1000;
        endcase
    endfunction

endpackage

// File: rtl/fq_measure_multi_channel.sv
// One measurement channel: input synchroniser, rising-edge detect, saturating edge
// counter and the scaled/saturated result register updated at each window end.
module fq_channel
    import fq_measure_pkg::*;
#(
    parameter int unsigned W           = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_sig,
    input  logic               i_terminal,
    input  logic [SCALE_W-1:0] i_scale,
    output logic [W-1:0]       o_result,
    output logic               o_overflow
);

    localparam int unsigned PW      = W + SCALE_W;
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [W-1:0]           r_edge_cnt;
    logic [W-1:0]           r_result;
    logic                   r_overflow;

    logic                   w_edge;
    logic [W-1:0]           w_total;
    logic [PW-1:0]          w_product;
    logic                   w_ovf;

    // w_total includes an edge seen in the terminal cycle, so it belongs to the ending window.
    always_comb begin
        w_edge    = r_sync[SYNC_STAGES-1] & ~r_prev;
        w_total   = (w_edge && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + W'(1) : r_edge_cnt;
        w_product = PW'(w_total) * PW'(i_scale);
        w_ovf     = (w_total == CNT_MAX) || (w_product[PW-1:W] != '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync     <= '0;
            r_prev     <= 1'b0;
            r_edge_cnt <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (i_terminal) begin
                r_edge_cnt <= '0;
                r_result   <= w_ovf ? CNT_MAX : w_product[W-1:0];
                r_overflow <= w_ovf;
            end else begin
                r_edge_cnt <= w_total;
            end
        end
    end

    assign o_result   = r_result;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/fq_measure_multi.sv
// Multi-channel frequency counter: shared gate-window timer with runtime-selectable
// length, one fq_channel per input, single valid strobe for all results.
module fq_measure_multi
    import fq_measure_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned W           = 32,
    parameter int unsigned REF_FREQ    = 1000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  ref_freq,
    input  logic                  nReset,
    input  logic [NCH-1:0]        input_freq,
    input  logic [1:0]            gate_sel,
    output logic [NCH-1:0][W-1:0] measured_freq,
    output logic                  meas_valid,
    output logic [NCH-1:0]        overflow,
    output logic                  gate_active
);

    localparam int unsigned GCW = $clog2(REF_FREQ);

    logic [GCW-1:0]     r_gate_cnt;
    gate_sel_t          r_gate_sel;
    logic               r_gate_active;
    logic               r_meas_valid;

    gate_sel_t          w_sel;
    logic [GCW-1:0]     w_gate_last;
    logic [SCALE_W-1:0] w_scale;
    logic               w_terminal;

    // The first window after reset release uses the live gate_sel until it is latched.
    always_comb begin
        w_sel       = r_gate_active ? r_gate_sel : gate_sel_t'(gate_sel);
        w_gate_last = GCW'(gate_cycles(REF_FREQ, w_sel) - 1);
        w_scale     = gate_scale(w_sel);
        w_terminal  = (r_gate_cnt == w_gate_last);
    end

    always_ff @(posedge ref_freq or negedge nReset) begin
        if (!nReset) begin
            r_gate_cnt    <= '0;
            r_gate_sel    <= GATE_1S;
            r_gate_active <= 1'b0;
            r_meas_valid  <= 1'b0;
        end else begin
            r_gate_active <= 1'b1;
            r_meas_valid  <= w_terminal;
            if (w_terminal) begin
                r_gate_cnt <= '0;
            end else begin
                r_gate_cnt <= r_gate_cnt + GCW'(1);
            end
            if (w_terminal || !r_gate_active) begin
                r_gate_sel <= gate_sel_t'(gate_sel);
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        fq_channel #(
            .W           (W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .i_clk      (ref_freq),
            .i_rst_n    (nReset),
            .i_sig      (input_freq[gi]),
            .i_terminal (w_terminal),
            .i_scale    (w_scale),
            .o_result   (measured_freq[gi]),
            .o_overflow (overflow[gi])
        );
    end

    assign meas_valid  = r_meas_valid;
    assign gate_active = r_gate_active;

endmodule

// File: tb/tb_fq_measure_multi.sv
// Bench for fq_measure_multi at REF_FREQ=10000 (gates of 10000/1000/100/10 cycles):
// dut_a is 2ch x 32b for the measurement table, dut_b is 2ch x 8b for saturation.
module tb_fq_measure_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst_a = 1'b0;
    logic       nrst_b = 1'b0;
    logic [1:0] sel_a  = 2'd0;
    logic [1:0] sel_b  = 2'd2;

    // tgl[1:0] drive dut_a, tgl[3:2] drive dut_b; hcfg = cycles per half-period, 0 = hold.
    logic [3:0] tgl     = '0;
    int         hcfg[4] = '{2, 13, 2, 0};
    int         hcnt[4] = '{0, 0, 0, 0};

    logic [1:0][31:0] mf_a;
    logic             valid_a;
    logic [1:0]       ovf_a;
    logic             act_a;
    logic [1:0][7:0]  mf_b;
    logic             valid_b;
    logic [1:0]       ovf_b;
    logic             act_b;

    int n_checks = 0;
    int n_fail   = 0;

    fq_measure_multi #(.NCH(2), .W(32), .REF_FREQ(10000), .SYNC_STAGES(2)) dut_a (
        .ref_freq      (clk),
        .nReset        (nrst_a),
        .input_freq    (tgl[1:0]),
        .gate_sel      (sel_a),
        .measured_freq (mf_a),
        .meas_valid    (valid_a),
        .overflow      (ovf_a),
        .gate_active   (act_a)
    );

    fq_measure_multi #(.NCH(2), .W(8), .REF_FREQ(10000), .SYNC_STAGES(2)) dut_b (
        .ref_freq      (clk),
        .nReset        (nrst_b),
        .input_freq    (tgl[3:2]),
        .gate_sel      (sel_b),
        .measured_freq (mf_b),
        .meas_valid    (valid_b),
        .overflow      (ovf_b),
        .gate_active   (act_b)
    );

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (hcfg[c] == 0) begin
                hcnt[c] = 0;
            end else if (hcnt[c] >= hcfg[c] - 1) begin
                tgl[c]  = ~tgl[c];
                hcnt[c] = 0;
            end else begin
                hcnt[c] = hcnt[c] + 1;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_valid(input bit use_b, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(use_b ? valid_b : valid_a) && cyc < budget);
        if (!(use_b ? valid_b : valid_a)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no meas_valid within %0d cycles", use_b ? "timeout_b" : "timeout_a", budget);
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        int         h0;
        int         h1;
        int         g;
        longint     lo0;
        longint     hi0;
        longint     lo1;
        longint     hi1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc;
        bit quiet;

        // G = 10000/10^sel cycles, S = 10^sel; period 2h cycles -> G/(2h) edges (+/-1) times S.
        vecs[0] = '{2'd0,  2, 13, 10000, 2499, 2501,  384,  385};
        vecs[1] = '{2'd1,  3,  7,  1000, 1660, 1670,  710,  720};
        vecs[2] = '{2'd2,  5,  0,   100,  900, 1100,    0,    0};
        vecs[3] = '{2'd3,  3,  2,    10, 1000, 2000, 2000, 3000};
        vecs[4] = '{2'd3,  0,  0,    10,    0,    0,    0,    0};

        repeat (3) @(negedge clk);
        chk("rst_mf_a",    longint'(mf_a[0] | mf_a[1]), 0, 0);
        chk("rst_ovf_a",   longint'(ovf_a), 0, 0);
        chk("rst_valid_a", longint'(valid_a), 0, 0);
        chk("rst_act_a",   longint'(act_a), 0, 0);
        chk("rst_mf_b",    longint'({mf_b[1], mf_b[0]}), 0, 0);
        $display("reset: mf_a=%0d/%0d act_a=%b mf_b=%0d/%0d", mf_a[0], mf_a[1], act_a, mf_b[0], mf_b[1]);

        // dut_b: 10 ms gate, ch0 at 2500 Hz -> 2500 > 255 saturates by product.
        nrst_b = 1'b1;
        wait_valid(1'b1, 20000, cyc);
        chk("b_first_gate", cyc, 100, 100);
        chk("b_prod_mf0",   longint'(mf_b[0]), 255, 255);
        chk("b_prod_ovf0",  longint'(ovf_b[0]), 1, 1);
        chk("b_ch1_mf",     longint'(mf_b[1]), 0, 0);
        chk("b_ch1_ovf",    longint'(ovf_b[1]), 0, 0);
        $display("b prod: cyc=%0d mf=%0d/%0d ovf=%b", cyc, mf_b[0], mf_b[1], ovf_b);

        // 1 s gate: edge counter passes 255 before ch0 is stopped mid-window.
        sel_b = 2'd0;
        wait_valid(1'b1, 20000, cyc);
        repeat (3000) @(negedge clk);
        hcfg[2] = 0;
        sel_b   = 2'd2;
        wait_valid(1'b1, 20000, cyc);
        chk("b_sat_gate", cyc + 3000, 10000, 10000);
        chk("b_sat_mf0",  longint'(mf_b[0]), 255, 255);
        chk("b_sat_ovf0", longint'(ovf_b[0]), 1, 1);
        chk("b_sat_mf1",  longint'(mf_b[1]), 0, 0);
        $display("b sat: cyc=%0d mf=%0d/%0d ovf=%b", cyc + 3000, mf_b[0], mf_b[1], ovf_b);

        wait_valid(1'b1, 20000, cyc);
        chk("b_clr_gate", cyc, 100, 100);
        chk("b_clr_mf0",  longint'(mf_b[0]), 0, 0);
        chk("b_clr_ovf0", longint'(ovf_b[0]), 0, 0);
        $display("b clear: cyc=%0d mf=%0d/%0d ovf=%b", cyc, mf_b[0], mf_b[1], ovf_b);

        // dut_a table: the window running when a vector is applied keeps its old gate and is discarded.
        for (int i = 0; i < 5; i++) begin
            sel_a   = vecs[i].sel;
            hcfg[0] = vecs[i].h0;
            hcfg[1] = vecs[i].h1;
            if (i == 0) begin
                nrst_a = 1'b1;
            end else begin
                wait_valid(1'b0, 20000, cyc);
            end
            wait_valid(1'b0, 20000, cyc);
            chk($sformatf("v%0d_gate", i), cyc, vecs[i].g, vecs[i].g);
            chk($sformatf("v%0d_ch0", i), longint'(mf_a[0]), vecs[i].lo0, vecs[i].hi0);
            chk($sformatf("v%0d_ch1", i), longint'(mf_a[1]), vecs[i].lo1, vecs[i].hi1);
            chk($sformatf("v%0d_ovf", i), longint'(ovf_a), 0, 0);
            chk($sformatf("v%0d_act", i), longint'(act_a), 1, 1);
            $display("vec %0d: sel=%0d gate=%0d ch0=%0d ch1=%0d ovf=%b", i, vecs[i].sel, cyc, mf_a[0], mf_a[1], ovf_a);
        end

        // Gate change 3000 cycles into a 1 s window must not shorten it.
        sel_a   = 2'd0;
        hcfg[0] = 2;
        hcfg[1] = 13;
        wait_valid(1'b0, 20000, cyc);
        repeat (3000) @(negedge clk);
        sel_a = 2'd3;
        wait_valid(1'b0, 20000, cyc);
        chk("mid_sel_gate", cyc + 3000, 10000, 10000);
        chk("mid_sel_ch0",  longint'(mf_a[0]), 2499, 2501);
        $display("mid-window sel change: gate=%0d ch0=%0d", cyc + 3000, mf_a[0]);
        wait_valid(1'b0, 20000, cyc);
        chk("mid_sel_next", cyc, 10, 10);
        $display("next window: gate=%0d ch0=%0d", cyc, mf_a[0]);

        // Reset 4000 cycles into a 1 s window.
        sel_a = 2'd0;
        wait_valid(1'b0, 20000, cyc);
        @(negedge clk);
        chk("valid_width", longint'(valid_a), 0, 0);
        repeat (3999) @(negedge clk);
        nrst_a = 1'b0;
        #1;
        chk("mid_rst_mf",  longint'(mf_a[0] | mf_a[1]), 0, 0);
        chk("mid_rst_ovf", longint'(ovf_a), 0, 0);
        chk("mid_rst_act", longint'(act_a), 0, 0);
        quiet = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (valid_a || act_a || (mf_a[0] != 0)) quiet = 1'b0;
        end
        chk("mid_rst_quiet", longint'(quiet), 1, 1);
        nrst_a = 1'b1;
        wait_valid(1'b0, 20000, cyc);
        chk("post_rst_gate", cyc, 10000, 10000);
        chk("post_rst_ch0",  longint'(mf_a[0]), 2499, 2501);
        chk("post_rst_ch1",  longint'(mf_a[1]), 384, 385);
        $display("after reset: gate=%0d ch0=%0d ch1=%0d", cyc, mf_a[0], mf_a[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
